exu_alu_dpath_arb: RTL and testbench

Arbiter and sequencer for the shared EXU ALU datapath, which has three requester slots: ALU, BJP and AGU.
- Accepts valid/ready requests from the three requesters and grants at most one per cycle.
- Drives the datapath select, operation and operand inputs combinationally from the winner.
- Captures the datapath result into a one-entry response register, tagged with the requester ID.
- Sits between the EXU dispatch/AGU/BJP units and the ALU datapath module.

---
 rtl/exu_alu_dpath_arb_pkg.sv | 63 ++++++
 rtl/exu_alu_dpath_arb_rr.sv | 46 ++++
 rtl/exu_alu_dpath_arb.sv | 136 +++++++++++++
 tb/tb_exu_alu_dpath_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_alu_dpath_arb_pkg.sv
// Shared constants for the EXU ALU datapath arbiter: widths, op-bit indices, requester tags.
// Arbitration policy is selected by EXU_ALU_ARB_RR_EN (round-robin when defined).
package exu_alu_dpath_arb_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam int unsigned OPW_DEF = 5;

    // Op vector bit order is {add, or, xor, sltu, lui}
    localparam int unsigned OP_ADD  = 4;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_XOR  = 2;
    localparam int unsigned OP_SLTU = 1;
    localparam int unsigned OP_LUI  = 0;

    localparam logic [OPW_DEF-1:0] OP_ADD_VEC = OPW_DEF'(1) << OP_ADD;

    localparam logic [1:0] RSP_ID_NONE = 2'b00;
    localparam logic [1:0] RSP_ID_ALU  = 2'b01;
    localparam logic [1:0] RSP_ID_BJP  = 2'b10;
    localparam logic [1:0] RSP_ID_AGU  = 2'b11;

    // Bit positions of each requester in the 3-bit valid/grant vectors
    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_BJP = 2'd1;
    localparam logic [1:0] REQ_AGU = 2'd2;

    typedef enum logic {
        RspEmpty,
        RspFull
    } rsp_state_e;

    // First valid requester in the order i0, i1, i2, as a one-hot vector
    function automatic logic [2:0] pick_first(input logic [2:0] valid,
                                              input logic [1:0] i0,
                                              input logic [1:0] i1,
                                              input logic [1:0] i2);
        logic [2:0] g;
        g = '0;
        if (valid[i0]) begin
            g[i0] = 1'b1;
        end else if (valid[i1]) begin
            g[i1] = 1'b1;
        end else if (valid[i2]) begin
            g[i2] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [1:0] grant_to_tag(input logic [2:0] grant);
        logic [1:0] tag;
        tag = RSP_ID_NONE;
        if (grant[REQ_ALU]) begin
            tag = RSP_ID_ALU;
        end else if (grant[REQ_BJP]) begin
            tag = RSP_ID_BJP;
        end else if (grant[REQ_AGU]) begin
            tag = RSP_ID_AGU;
        end
        return tag;
    endfunction

endpackage

// File: rtl/exu_alu_dpath_arb_rr.sv
// 3-way grant generator. EXU_ALU_ARB_RR_EN selects round-robin with a one-hot pointer;
// otherwise fixed priority BJP > AGU > ALU with no state.
module exu_alu_arb_rr
    import exu_alu_dpath_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [2:0] i_valid,
    output logic [2:0] o_grant
);

    logic [2:0] w_pick;

`ifdef EXU_ALU_ARB_RR_EN
    logic [2:0] r_ptr;

    always_comb begin
        w_pick = '0;
        unique case (r_ptr)
            3'b010:  w_pick = pick_first(i_valid, REQ_BJP, REQ_AGU, REQ_ALU);
            3'b100:  w_pick = pick_first(i_valid, REQ_AGU, REQ_ALU, REQ_BJP);
            default: w_pick = pick_first(i_valid, REQ_ALU, REQ_BJP, REQ_AGU);
        endcase
    end

    // Rotate winner one slot up so the next requester in cyclic order leads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 3'b001;
        end else if (|o_grant) begin
            r_ptr <= {o_grant[1:0], o_grant[2]};
        end
    end
`else
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    always_comb begin
        w_pick = pick_first(i_valid, REQ_BJP, REQ_AGU, REQ_ALU);
    end
`endif

    assign o_grant = i_en ? w_pick : 3'b000;

endmodule

// File: rtl/exu_alu_dpath_arb.sv
// Arbiter/sequencer for the shared EXU ALU datapath with a one-entry tagged response register.
// Arbitration policy: round-robin when EXU_ALU_ARB_RR_EN is defined, else BJP > AGU > ALU.
module exu_alu_dpath_arb
    import exu_alu_dpath_arb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned OPW  = OPW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            alu_req_valid,
    output logic            alu_req_ready,
    input  logic [OPW-1:0]  alu_req_op,
    input  logic [XLEN-1:0] alu_req_op1,
    input  logic [XLEN-1:0] alu_req_op2,

    input  logic            bjp_req_valid,
    output logic            bjp_req_ready,
    input  logic [XLEN-1:0] bjp_req_op1,
    input  logic [XLEN-1:0] bjp_req_op2,

    input  logic            agu_req_valid,
    output logic            agu_req_ready,
    input  logic [XLEN-1:0] agu_req_op1,
    input  logic [XLEN-1:0] agu_req_op2,

    output logic            dp_alu_sel,
    output logic            dp_bjp_sel,
    output logic            dp_agu_sel,
    output logic [OPW-1:0]  dp_op,
    output logic [XLEN-1:0] dp_op1,
    output logic [XLEN-1:0] dp_op2,
    input  logic [XLEN-1:0] dp_res,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [1:0]      rsp_id,
    output logic [XLEN-1:0] rsp_res
);

    logic [2:0]      w_valid;
    logic [2:0]      w_grant;
    logic            w_can_issue;
    logic            w_any_grant;
    rsp_state_e      r_state;
    rsp_state_e      w_state_d;
    logic [1:0]      r_rsp_id;
    logic [XLEN-1:0] r_rsp_res;

    assign w_valid = {agu_req_valid, bjp_req_valid, alu_req_valid};

    // rst_n gating keeps every ready low while reset is held
    assign w_can_issue = rst_n & ((r_state == RspEmpty) | rsp_ready);

    exu_alu_arb_rr u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_can_issue),
        .i_valid (w_valid),
        .o_grant (w_grant)
    );

    assign w_any_grant   = |w_grant;
    assign alu_req_ready = w_grant[REQ_ALU];
    assign bjp_req_ready = w_grant[REQ_BJP];
    assign agu_req_ready = w_grant[REQ_AGU];
    assign dp_alu_sel    = w_grant[REQ_ALU];
    assign dp_bjp_sel    = w_grant[REQ_BJP];
    assign dp_agu_sel    = w_grant[REQ_AGU];

    always_comb begin
        dp_op  = '0;
        dp_op1 = '0;
        dp_op2 = '0;
        if (w_grant[REQ_ALU]) begin
            dp_op  = alu_req_op;
            dp_op1 = alu_req_op1;
            dp_op2 = alu_req_op2;
        end else if (w_grant[REQ_BJP]) begin
            dp_op  = OPW'(OP_ADD_VEC);
            dp_op1 = bjp_req_op1;
            dp_op2 = bjp_req_op2;
        end else if (w_grant[REQ_AGU]) begin
            dp_op  = OPW'(OP_ADD_VEC);
            dp_op1 = agu_req_op1;
            dp_op2 = agu_req_op2;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            RspEmpty: begin
                if (w_any_grant) begin
                    w_state_d = RspFull;
                end
            end
            RspFull: begin
                if (rsp_ready && !w_any_grant) begin
                    w_state_d = RspEmpty;
                end
            end
            default: w_state_d = RspEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RspEmpty;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_id  <= RSP_ID_NONE;
            r_rsp_res <= '0;
        end else if (w_any_grant) begin
            r_rsp_id  <= grant_to_tag(w_grant);
            r_rsp_res <= dp_res;
        end
    end

    assign rsp_valid = (r_state == RspFull);
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;

    // A held response must never be overwritten
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(w_grant));
    a_no_grant_when_held: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |-> !w_any_grant);

endmodule

// File: tb/tb_exu_alu_dpath_arb.sv
// Scoreboard bench for exu_alu_dpath_arb: directed plan cases plus randomized traffic
// against a transaction-level model of arbitration, response buffering and the ALU ops.
module tb_exu_alu_dpath_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_req_valid = 1'b0, bjp_req_valid = 1'b0, agu_req_valid = 1'b0;
    logic        alu_req_ready, bjp_req_ready, agu_req_ready;
    logic [4:0]  alu_req_op = '0;
    logic [31:0] alu_req_op1 = '0, alu_req_op2 = '0;
    logic [31:0] bjp_req_op1 = '0, bjp_req_op2 = '0;
    logic [31:0] agu_req_op1 = '0, agu_req_op2 = '0;
    logic        dp_alu_sel, dp_bjp_sel, dp_agu_sel;
    logic [4:0]  dp_op;
    logic [31:0] dp_op1, dp_op2, dp_res;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_res;

    exu_alu_dpath_arb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_req_valid (alu_req_valid),
        .alu_req_ready (alu_req_ready),
        .alu_req_op    (alu_req_op),
        .alu_req_op1   (alu_req_op1),
        .alu_req_op2   (alu_req_op2),
        .bjp_req_valid (bjp_req_valid),
        .bjp_req_ready (bjp_req_ready),
        .bjp_req_op1   (bjp_req_op1),
        .bjp_req_op2   (bjp_req_op2),
        .agu_req_valid (agu_req_valid),
        .agu_req_ready (agu_req_ready),
        .agu_req_op1   (agu_req_op1),
        .agu_req_op2   (agu_req_op2),
        .dp_alu_sel    (dp_alu_sel),
        .dp_bjp_sel    (dp_bjp_sel),
        .dp_agu_sel    (dp_agu_sel),
        .dp_op         (dp_op),
        .dp_op1        (dp_op1),
        .dp_op2        (dp_op2),
        .dp_res        (dp_res),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_res       (rsp_res)
    );

    always #5 clk = ~clk;

    // Reference ALU: op bits {add, or, xor, sltu, lui}; lui passes op2 through
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        if (op[4]) r = r | (a + b);
        if (op[3]) r = r | (a | b);
        if (op[2]) r = r | (a ^ b);
        if (op[1]) r = r | ((a < b) ? 32'd1 : 32'd0);
        if (op[0]) r = r | b;
        return r;
    endfunction

    // Behavioural datapath driven by the DUT's outputs
    assign dp_res = ref_alu(dp_op, dp_op1, dp_op2);

    int checks = 0;
    int failures = 0;

    // Requester model state: index 0 ALU, 1 BJP, 2 AGU
    logic [2:0]  v = '0;
    logic [4:0]  aop = '0;
    logic [31:0] a1 [3];
    logic [31:0] a2 [3];
    logic        rr = 1'b0;
    bit          m_full = 0;
    int          m_ptr = 0;
    logic [33:0] q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] vv, input int ptr);
`ifdef EXU_ALU_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            if (vv[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
`else
        if (vv[1]) return 1;
        if (vv[2]) return 2;
        if (vv[0]) return 0;
        return -1;
`endif
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rnd_op();
        case ($urandom_range(0, 9))
            0: return 5'b0;
            1: return 5'($urandom_range(0, 31));
            default: return 5'b1 << $urandom_range(0, 4);
        endcase
    endfunction

    // One cycle: drive at negedge, check combinational outputs, advance the model
    task automatic step();
        int          w;
        bit          can;
        logic [2:0]  eg;
        logic [4:0]  eop;
        logic [31:0] e1, e2;
        @(negedge clk);
        alu_req_valid = v[0]; alu_req_op = aop;
        alu_req_op1 = a1[0]; alu_req_op2 = a2[0];
        bjp_req_valid = v[1]; bjp_req_op1 = a1[1]; bjp_req_op2 = a2[1];
        agu_req_valid = v[2]; agu_req_op1 = a1[2]; agu_req_op2 = a2[2];
        rsp_ready = rr;
        #1;
        chk("rsp_valid", 128'(rsp_valid), 128'(m_full));
        can = !m_full || rr;
        w = can ? pick(v, m_ptr) : -1;
        eg = '0; eop = '0; e1 = '0; e2 = '0;
        if (w >= 0) begin
            eg = 3'b001 << w;
            eop = (w == 0) ? aop : 5'b10000;
            e1 = a1[w];
            e2 = a2[w];
        end
        chk("ready", 128'({agu_req_ready, bjp_req_ready, alu_req_ready}), 128'(eg));
        chk("dp", 128'({dp_agu_sel, dp_bjp_sel, dp_alu_sel, dp_op, dp_op1, dp_op2}),
            128'({eg, eop, e1, e2}));
        if (w >= 0) begin
            q.push_back({2'(w + 1), ref_alu(eop, e1, e2)});
            v[w] = 1'b0;
            m_full = 1;
            m_ptr = (w + 1) % 3;
        end else if (m_full && rr) begin
            m_full = 0;
        end
    endtask

    task automatic fill_all();
        for (int i = 0; i < 3; i++) begin
            if (!v[i]) begin
                v[i] = 1'b1;
                a1[i] = rnd_val();
                a2[i] = rnd_val();
                if (i == 0) aop = rnd_op();
            end
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 3; i++) begin
            if (!v[i] && $urandom_range(0, 99) < 60) begin
                v[i] = 1'b1;
                a1[i] = rnd_val();
                a2[i] = rnd_val();
                if (i == 0) aop = rnd_op();
            end
        end
        rr = ($urandom_range(0, 99) < 70);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_ready", 128'({agu_req_ready, bjp_req_ready, alu_req_ready}), 128'(0));
        chk("rst_sel", 128'({dp_agu_sel, dp_bjp_sel, dp_alu_sel}), 128'(0));
        chk("rst_rsp", 128'({rsp_id, rsp_res}), 128'(0));
        q.delete();
        m_full = 0;
        m_ptr = 0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compare the held response with the scoreboard head, pop on consumption
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual id=%0h res=%0h required=none",
                             rsp_id, rsp_res);
                end else begin
                    chk("rsp", 128'({rsp_id, rsp_res}), 128'(q[0]));
                    if (rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            a1[i] = '0;
            a2[i] = '0;
        end
        #2;
        chk("init_rsp", 128'({rsp_valid, rsp_id, rsp_res}), 128'(0));
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;

        // ALU add 5 + 7
        v = 3'b001; aop = 5'b10000; a1[0] = 32'd5; a2[0] = 32'd7; rr = 1'b1;
        step();
        step();

        // sltu 1 < 2, then AGU add wrapping to zero, then idle drain
        v = 3'b001; aop = 5'b00010; a1[0] = 32'd1; a2[0] = 32'd2;
        step();
        v = 3'b100; a1[2] = 32'h8000_0000; a2[2] = 32'h8000_0000;
        step();
        step();
        step();

        // All three requesters valid continuously
        rr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            fill_all();
            step();
        end
        v = '0;
        step();
        step();

        // Backpressure with AGU waiting, then release
        v = 3'b001; aop = 5'b01000; a1[0] = 32'h00F0; a2[0] = 32'h0F00; rr = 1'b0;
        step();
        v = 3'b100; a1[2] = 32'd100; a2[2] = 32'd23;
        repeat (3) step();
        rr = 1'b1;
        step();
        v = '0;
        step();
        step();

        // Reset while a result is held, then all requesters valid
        v = 3'b001; aop = 5'b00100; a1[0] = 32'hAAAA_5555; a2[0] = 32'hFFFF_0000; rr = 1'b0;
        step();
        step();
        v = '0;
        do_reset();
        rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill_all();
            step();
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            fill_rand();
            step();
        end

        // Drain whatever is still pending
        rr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        v = '0;
        repeat (3) step();
        chk("drain_queue", 128'(q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
